// File: rtl/lsu_split_access_if.sv
// Request, flush, memory-beat and response signals of the load/store split unit.
// slave = the LSU itself; master = the pipeline plus memory that surround it.
interface lsu_split_access_if #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned ADDR_W     = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_store;
  logic [1:0]              req_size;
  logic                    req_signed;
  logic [ADDR_W-1:0]       req_addr;
  logic [8*DATA_BYTES-1:0] req_wdata;
  logic [4:0]              req_tgt;
  logic                    flush;

  logic                    mem_valid;
  logic                    mem_ready;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_BYTES-1:0]   mem_we;
  logic [8*DATA_BYTES-1:0] mem_wdata;
  logic                    mem_rvalid;
  logic [8*DATA_BYTES-1:0] mem_rdata;

  logic                    resp_valid;
  logic [8*DATA_BYTES-1:0] resp_data;
  logic [4:0]              resp_tgt;
  logic                    resp_split;
  logic                    resp_err;

  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, req_tgt, flush,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_addr, mem_we, mem_wdata,
    output resp_valid, resp_data, resp_tgt, resp_split, resp_err
  );

  modport master (
    output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, req_tgt, flush,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_addr, mem_we, mem_wdata,
    input  resp_valid, resp_data, resp_tgt, resp_split, resp_err
  );
endinterface

// File: rtl/lsu_split_access.sv
// Load/store access unit: one request at a time, bus-word crossing accesses are
// split into two aligned beats; loads are merged and sign/zero extended.
module lsu_split_access #(
  parameter int unsigned DATA_BYTES       = 4,
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned ALLOW_MISALIGNED = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  lsu_split_access_if.slave  bus
);
  localparam int unsigned OFF_W = $clog2(DATA_BYTES);
  localparam int unsigned DW    = 8 * DATA_BYTES;
  localparam int unsigned NW    = OFF_W + 2;
  localparam int unsigned SHW   = OFF_W + 4;
  localparam logic [1:0]    MAX_SIZE = 2'(OFF_W);
  localparam logic [NW-1:0] BUS_N    = NW'(DATA_BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              beat_q, beat_d;
  logic              kill_q, kill_d;
  logic              store_q, store_d;
  logic              signed_q, signed_d;
  logic              split_q, split_d;
  logic              err_q, err_d;
  logic [1:0]        size_q, size_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [4:0]        tgt_q, tgt_d;
  logic [2*DW-1:0]   buf_q, buf_d;

  // Decode of the incoming request
  logic [OFF_W-1:0] acc_off;
  logic [NW-1:0]    acc_n, acc_end;
  logic             acc_split, acc_err;

  assign acc_off   = bus.req_addr[OFF_W-1:0];
  assign acc_n     = NW'(1) << bus.req_size;
  assign acc_end   = NW'(acc_off) + acc_n;
  assign acc_split = acc_end > BUS_N;
  assign acc_err   = (bus.req_size > MAX_SIZE) || (acc_split && (ALLOW_MISALIGNED == 0));

  // Beat generation from the registered request
  logic [NW-1:0]         cur_n, cur_end;
  logic [SHW-1:0]        sh0, sh1;
  logic [DATA_BYTES-1:0] lane_mask;
  logic [DW-1:0]         beat_wdata;
  logic [ADDR_W-1:0]     beat_addr;

  assign cur_n      = NW'(1) << size_q;
  assign cur_end    = NW'(off_q) + cur_n;
  assign sh0        = {1'b0, off_q, 3'b000};
  assign sh1        = SHW'(DW) - sh0;
  assign beat_wdata = beat_q ? (wdata_q >> sh1) : (wdata_q << sh0);
  assign beat_addr  = beat_q ? (base_q + ADDR_W'(DATA_BYTES)) : base_q;

  always_comb begin
    lane_mask = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (!beat_q) lane_mask[i] = (NW'(i) >= NW'(off_q)) && (NW'(i) < cur_end);
      else         lane_mask[i] = NW'(i) < (cur_end - BUS_N);
    end
  end

  // Load merge: the two buffer halves form a contiguous 2-word window
  logic [DW-1:0] merged, load_res;
  logic          sgn;

  always_comb begin
    merged   = DW'(buf_q >> sh0);
    sgn      = 1'b0;
    load_res = '0;
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      if (NW'(k + 1) == cur_n) sgn = merged[8*k+7];
    end
    for (int unsigned k = 0; k < DATA_BYTES; k++) begin
      if (NW'(k) < cur_n) load_res[8*k +: 8] = merged[8*k +: 8];
      else                load_res[8*k +: 8] = {8{sgn & signed_q}};
    end
  end

  logic killed, more_beats;
  assign killed     = kill_q | bus.flush;
  assign more_beats = split_q && !beat_q && !killed;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    kill_d   = kill_q;
    store_d  = store_q;
    signed_d = signed_q;
    split_d  = split_q;
    err_d    = err_q;
    size_d   = size_q;
    off_d    = off_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    tgt_d    = tgt_q;
    buf_d    = buf_q;
    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (bus.req_valid) begin
          store_d  = bus.req_store;
          signed_d = bus.req_signed;
          size_d   = bus.req_size;
          off_d    = acc_off;
          base_d   = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wdata_d  = bus.req_wdata;
          tgt_d    = bus.req_tgt;
          split_d  = acc_split;
          err_d    = acc_err;
          beat_d   = 1'b0;
          // A flush coinciding with accept kills the request before any beat
          kill_d   = bus.flush;
          state_d  = (acc_err || bus.flush) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.flush) kill_d = 1'b1;
        if (bus.mem_ready) begin
          if (!store_q)        state_d = S_WAIT;
          else if (more_beats) beat_d  = 1'b1;
          else                 state_d = S_RESP;
        end
      end
      S_WAIT: begin
        if (bus.flush) kill_d = 1'b1;
        if (bus.mem_rvalid) begin
          if (beat_q) buf_d[2*DW-1:DW] = bus.mem_rdata;
          else        buf_d[DW-1:0]    = bus.mem_rdata;
          if (more_beats) begin
            beat_d  = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
        beat_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      beat_q   <= 1'b0;
      kill_q   <= 1'b0;
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      off_q    <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      tgt_q    <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      kill_q   <= kill_d;
      store_q  <= store_d;
      signed_q <= signed_d;
      split_q  <= split_d;
      err_q    <= err_d;
      size_q   <= size_d;
      off_q    <= off_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      tgt_q    <= tgt_d;
      buf_q    <= buf_d;
    end
  end

  logic issuing, resp_fire;
  assign issuing   = (state_q == S_ISSUE);
  assign resp_fire = (state_q == S_RESP) && !kill_q;

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.mem_valid  = issuing;
  assign bus.mem_addr   = issuing ? beat_addr : '0;
  assign bus.mem_we     = (issuing && store_q) ? lane_mask : '0;
  assign bus.mem_wdata  = (issuing && store_q) ? beat_wdata : '0;
  assign bus.resp_valid = resp_fire;
  assign bus.resp_data  = (resp_fire && !store_q && !err_q) ? load_res : '0;
  assign bus.resp_tgt   = resp_fire ? tgt_q : '0;
  assign bus.resp_split = resp_fire ? split_q : 1'b0;
  assign bus.resp_err   = resp_fire ? err_q : 1'b0;
endmodule

// File: tb/tb_lsu_split_access.sv
// Directed bench for lsu_split_access: one DUT splits crossing accesses, a
// second one (misalignment disabled) exercises the error path.
module tb_lsu_split_access;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu_split_access_if #(.DATA_BYTES(4), .ADDR_W(32)) ifa ();
  lsu_split_access_if #(.DATA_BYTES(4), .ADDR_W(32)) ifb ();

  lsu_split_access #(.DATA_BYTES(4), .ADDR_W(32), .ALLOW_MISALIGNED(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  lsu_split_access #(.DATA_BYTES(4), .ADDR_W(32), .ALLOW_MISALIGNED(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.req_valid = 0; ifa.req_store = 0; ifa.req_size = 0; ifa.req_signed = 0;
    ifa.req_addr = 0; ifa.req_wdata = 0; ifa.req_tgt = 0; ifa.flush = 0;
    ifa.mem_ready = 0; ifa.mem_rvalid = 0; ifa.mem_rdata = 0;
    ifb.req_valid = 0; ifb.req_store = 0; ifb.req_size = 0; ifb.req_signed = 0;
    ifb.req_addr = 0; ifb.req_wdata = 0; ifb.req_tgt = 0; ifb.flush = 0;
    ifb.mem_ready = 0; ifb.mem_rvalid = 0; ifb.mem_rdata = 0;
  endtask

  // Presents one request to dut_a (assumed idle) and returns one cycle after accept.
  task automatic req_a(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] tg);
    ifa.req_store = st; ifa.req_size = sz; ifa.req_signed = sg;
    ifa.req_addr = ad; ifa.req_wdata = wd; ifa.req_tgt = tg; ifa.req_valid = 1;
    step();
    ifa.req_valid = 0;
  endtask

  task automatic req_b(input logic st, input logic [1:0] sz, input logic [31:0] ad, input logic [4:0] tg);
    ifb.req_store = st; ifb.req_size = sz; ifb.req_signed = 0;
    ifb.req_addr = ad; ifb.req_wdata = 0; ifb.req_tgt = tg; ifb.req_valid = 1;
    step();
    ifb.req_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2;
    total++; if (ifa.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ifa.req_ready); end
    total++; if (ifa.mem_valid !== 1'b0) begin bad++; $display("FAIL rst_mem_valid got=%b exp=0", ifa.mem_valid); end
    total++; if (ifa.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", ifa.resp_valid); end
    total++; if (ifa.mem_we !== 4'h0) begin bad++; $display("FAIL rst_we got=%h exp=0", ifa.mem_we); end
    total++; if (ifb.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_b got=%b exp=1", ifb.req_ready); end
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic test_store_aligned();
    ifa.mem_ready = 1;
    total++; if (ifa.req_ready !== 1'b1) begin bad++; $display("FAIL st_al_ready0 got=%b exp=1", ifa.req_ready); end
    req_a(1, 2, 0, 32'h100, 32'hDEADBEEF, 5'd5);
    total++; if (ifa.mem_valid !== 1'b1) begin bad++; $display("FAIL st_al_valid got=%b exp=1", ifa.mem_valid); end
    total++; if (ifa.mem_addr !== 32'h100) begin bad++; $display("FAIL st_al_addr got=%h exp=100", ifa.mem_addr); end
    total++; if (ifa.mem_we !== 4'hF) begin bad++; $display("FAIL st_al_we got=%h exp=f", ifa.mem_we); end
    total++; if (ifa.mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL st_al_wdata got=%h exp=deadbeef", ifa.mem_wdata); end
    total++; if (ifa.req_ready !== 1'b0) begin bad++; $display("FAIL st_al_busy got=%b exp=0", ifa.req_ready); end
    total++; if (ifa.resp_valid !== 1'b0) begin bad++; $display("FAIL st_al_early_resp got=%b exp=0", ifa.resp_valid); end
    step();
    total++; if (ifa.resp_valid !== 1'b1) begin bad++; $display("FAIL st_al_resp got=%b exp=1", ifa.resp_valid); end
    total++; if (ifa.resp_split !== 1'b0) begin bad++; $display("FAIL st_al_split got=%b exp=0", ifa.resp_split); end
    total++; if (ifa.resp_tgt !== 5'd5) begin bad++; $display("FAIL st_al_tgt got=%0d exp=5", ifa.resp_tgt); end
    total++; if (ifa.resp_data !== 32'h0) begin bad++; $display("FAIL st_al_data got=%h exp=0", ifa.resp_data); end
    total++; if (ifa.mem_valid !== 1'b0) begin bad++; $display("FAIL st_al_nobeat got=%b exp=0", ifa.mem_valid); end
    step();
    total++; if (ifa.req_ready !== 1'b1) begin bad++; $display("FAIL st_al_ready got=%b exp=1", ifa.req_ready); end
  endtask

  task automatic test_store_split();
    ifa.mem_ready = 1;
    req_a(1, 2, 0, 32'h103, 32'h11223344, 5'd6);
    total++; if (ifa.mem_addr !== 32'h100) begin bad++; $display("FAIL st_sp_addr0 got=%h exp=100", ifa.mem_addr); end
    total++; if (ifa.mem_we !== 4'h8) begin bad++; $display("FAIL st_sp_we0 got=%h exp=8", ifa.mem_we); end
    total++; if (ifa.mem_wdata !== 32'h44000000) begin bad++; $display("FAIL st_sp_wd0 got=%h exp=44000000", ifa.mem_wdata); end
    step();
    total++; if (ifa.mem_valid !== 1'b1) begin bad++; $display("FAIL st_sp_valid1 got=%b exp=1", ifa.mem_valid); end
    total++; if (ifa.mem_addr !== 32'h104) begin bad++; $display("FAIL st_sp_addr1 got=%h exp=104", ifa.mem_addr); end
    total++; if (ifa.mem_we !== 4'h7) begin bad++; $display("FAIL st_sp_we1 got=%h exp=7", ifa.mem_we); end
    total++; if (ifa.mem_wdata !== 32'h00112233) begin bad++; $display("FAIL st_sp_wd1 got=%h exp=00112233", ifa.mem_wdata); end
    step();
    total++; if (ifa.resp_valid !== 1'b1) begin bad++; $display("FAIL st_sp_resp got=%b exp=1", ifa.resp_valid); end
    total++; if (ifa.resp_split !== 1'b1) begin bad++; $display("FAIL st_sp_split got=%b exp=1", ifa.resp_split); end
    step();
  endtask

  task automatic test_load_split(input logic sg, input logic [31:0] exp);
    ifa.mem_ready = 1;
    req_a(0, 1, sg, 32'h203, 32'h0, 5'd7);
    total++; if (ifa.mem_addr !== 32'h200) begin bad++; $display("FAIL ld_sp_addr0 got=%h exp=200", ifa.mem_addr); end
    total++; if (ifa.mem_we !== 4'h0) begin bad++; $display("FAIL ld_sp_we got=%h exp=0", ifa.mem_we); end
    step();
    ifa.mem_rvalid = 1; ifa.mem_rdata = 32'hAB000000;
    total++; if (ifa.mem_valid !== 1'b0) begin bad++; $display("FAIL ld_sp_wait got=%b exp=0", ifa.mem_valid); end
    step();
    ifa.mem_rvalid = 0;
    total++; if (ifa.mem_addr !== 32'h204) begin bad++; $display("FAIL ld_sp_addr1 got=%h exp=204", ifa.mem_addr); end
    step();
    ifa.mem_rvalid = 1; ifa.mem_rdata = 32'h000000FF;
    total++; if (ifa.resp_valid !== 1'b0) begin bad++; $display("FAIL ld_sp_early got=%b exp=0", ifa.resp_valid); end
    step();
    ifa.mem_rvalid = 0;
    total++; if (ifa.resp_valid !== 1'b1) begin bad++; $display("FAIL ld_sp_resp got=%b exp=1", ifa.resp_valid); end
    total++; if (ifa.resp_data !== exp) begin bad++; $display("FAIL ld_sp_data got=%h exp=%h", ifa.resp_data, exp); end
    total++; if (ifa.resp_split !== 1'b1) begin bad++; $display("FAIL ld_sp_split got=%b exp=1", ifa.resp_split); end
    total++; if (ifa.resp_tgt !== 5'd7) begin bad++; $display("FAIL ld_sp_tgt got=%0d exp=7", ifa.resp_tgt); end
    step();
  endtask

  task automatic test_load_stall();
    ifa.mem_ready = 1;
    req_a(0, 1, 1, 32'h203, 32'h0, 5'd8);
    step();
    ifa.mem_rvalid = 1; ifa.mem_rdata = 32'hAB000000;
    step();
    ifa.mem_rvalid = 0; ifa.mem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      total++; if (ifa.mem_valid !== 1'b1 || ifa.mem_addr !== 32'h204 || ifa.mem_we !== 4'h0) begin
        bad++; $display("FAIL ld_stall_hold got=%b/%h/%h exp=1/204/0", ifa.mem_valid, ifa.mem_addr, ifa.mem_we);
      end
      step();
    end
    ifa.mem_ready = 1;
    step();
    ifa.mem_rvalid = 1; ifa.mem_rdata = 32'h000000FF;
    total++; if (ifa.resp_valid !== 1'b0) begin bad++; $display("FAIL ld_stall_early got=%b exp=0", ifa.resp_valid); end
    step();
    ifa.mem_rvalid = 0;
    total++; if (ifa.resp_valid !== 1'b1) begin bad++; $display("FAIL ld_stall_resp got=%b exp=1", ifa.resp_valid); end
    total++; if (ifa.resp_data !== 32'hFFFFFFAB) begin bad++; $display("FAIL ld_stall_data got=%h exp=ffffffab", ifa.resp_data); end
    step();
  endtask

  task automatic test_load_byte();
    ifa.mem_ready = 1;
    req_a(0, 0, 1, 32'h102, 32'h0, 5'd3);
    total++; if (ifa.mem_addr !== 32'h100) begin bad++; $display("FAIL ld_b_addr got=%h exp=100", ifa.mem_addr); end
    step();
    ifa.mem_rvalid = 1; ifa.mem_rdata = 32'h00800000;
    step();
    ifa.mem_rvalid = 0;
    total++; if (ifa.resp_valid !== 1'b1) begin bad++; $display("FAIL ld_bs_resp got=%b exp=1", ifa.resp_valid); end
    total++; if (ifa.resp_data !== 32'hFFFFFF80) begin bad++; $display("FAIL ld_bs_data got=%h exp=ffffff80", ifa.resp_data); end
    total++; if (ifa.resp_split !== 1'b0) begin bad++; $display("FAIL ld_bs_split got=%b exp=0", ifa.resp_split); end
    step();
    req_a(0, 0, 0, 32'h10, 32'h0, 5'd4);
    total++; if (ifa.mem_addr !== 32'h10) begin bad++; $display("FAIL ld_bu_addr got=%h exp=10", ifa.mem_addr); end
    step();
    ifa.mem_rvalid = 1; ifa.mem_rdata = 32'h00800000;
    step();
    ifa.mem_rvalid = 0;
    total++; if (ifa.resp_valid !== 1'b1) begin bad++; $display("FAIL ld_bu_resp got=%b exp=1", ifa.resp_valid); end
    total++; if (ifa.resp_data !== 32'h0) begin bad++; $display("FAIL ld_bu_data got=%h exp=0", ifa.resp_data); end
    step();
  endtask

  task automatic test_error();
    ifb.mem_ready = 1;
    req_b(0, 2, 32'h101, 5'd9);
    total++; if (ifb.mem_valid !== 1'b0) begin bad++; $display("FAIL err_mis_nobeat got=%b exp=0", ifb.mem_valid); end
    total++; if (ifb.resp_valid !== 1'b1) begin bad++; $display("FAIL err_mis_resp got=%b exp=1", ifb.resp_valid); end
    total++; if (ifb.resp_err !== 1'b1) begin bad++; $display("FAIL err_mis_err got=%b exp=1", ifb.resp_err); end
    total++; if (ifb.resp_data !== 32'h0) begin bad++; $display("FAIL err_mis_data got=%h exp=0", ifb.resp_data); end
    total++; if (ifb.resp_tgt !== 5'd9) begin bad++; $display("FAIL err_mis_tgt got=%0d exp=9", ifb.resp_tgt); end
    step();
    total++; if (ifb.req_ready !== 1'b1) begin bad++; $display("FAIL err_mis_ready got=%b exp=1", ifb.req_ready); end
    req_b(0, 3, 32'h0, 5'd10);
    total++; if (ifb.mem_valid !== 1'b0 || ifb.resp_valid !== 1'b1 || ifb.resp_err !== 1'b1) begin
      bad++; $display("FAIL err_sz_b got=%b/%b/%b exp=0/1/1", ifb.mem_valid, ifb.resp_valid, ifb.resp_err);
    end
    step();
    ifa.mem_ready = 1;
    req_a(0, 3, 0, 32'h0, 32'h0, 5'd11);
    total++; if (ifa.mem_valid !== 1'b0 || ifa.resp_valid !== 1'b1 || ifa.resp_err !== 1'b1) begin
      bad++; $display("FAIL err_sz_a got=%b/%b/%b exp=0/1/1", ifa.mem_valid, ifa.resp_valid, ifa.resp_err);
    end
    step();
  endtask

  task automatic test_flush();
    ifa.flush = 1;
    step();
    ifa.flush = 0; ifa.mem_ready = 1;
    req_a(1, 2, 0, 32'h40, 32'h01020304, 5'd12);
    step();
    total++; if (ifa.resp_valid !== 1'b1) begin bad++; $display("FAIL fl_idle_resp got=%b exp=1", ifa.resp_valid); end
    step();
    ifa.mem_ready = 0;
    req_a(1, 2, 0, 32'h0FE, 32'hA1B2C3D4, 5'd13);
    ifa.flush = 1;
    total++; if (ifa.mem_addr !== 32'h0FC || ifa.mem_we !== 4'hC || ifa.mem_wdata !== 32'hC3D40000) begin
      bad++; $display("FAIL fl_beat0 got=%h/%h/%h exp=fc/c/c3d40000", ifa.mem_addr, ifa.mem_we, ifa.mem_wdata);
    end
    step();
    ifa.flush = 0;
    total++; if (ifa.mem_valid !== 1'b1 || ifa.mem_addr !== 32'h0FC || ifa.mem_we !== 4'hC) begin
      bad++; $display("FAIL fl_hold got=%b/%h/%h exp=1/fc/c", ifa.mem_valid, ifa.mem_addr, ifa.mem_we);
    end
    ifa.mem_ready = 1;
    step();
    total++; if (ifa.mem_valid !== 1'b0) begin bad++; $display("FAIL fl_nobeat1 got=%b exp=0", ifa.mem_valid); end
    total++; if (ifa.resp_valid !== 1'b0) begin bad++; $display("FAIL fl_noresp got=%b exp=0", ifa.resp_valid); end
    step();
    total++; if (ifa.req_ready !== 1'b1 || ifa.resp_valid !== 1'b0 || ifa.mem_valid !== 1'b0) begin
      bad++; $display("FAIL fl_idle got=%b/%b/%b exp=1/0/0", ifa.req_ready, ifa.resp_valid, ifa.mem_valid);
    end
    ifa.flush = 1;
    req_a(0, 2, 0, 32'h80, 32'h0, 5'd14);
    ifa.flush = 0;
    total++; if (ifa.mem_valid !== 1'b0 || ifa.resp_valid !== 1'b0) begin
      bad++; $display("FAIL fl_accept got=%b/%b exp=0/0", ifa.mem_valid, ifa.resp_valid);
    end
    step();
    total++; if (ifa.req_ready !== 1'b1 || ifa.resp_valid !== 1'b0) begin
      bad++; $display("FAIL fl_accept_idle got=%b/%b exp=1/0", ifa.req_ready, ifa.resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    ifa.mem_ready = 1;
    req_a(0, 1, 1, 32'h203, 32'h0, 5'd2);
    step();
    ifa.mem_rvalid = 1; ifa.mem_rdata = 32'hAB000000;
    step();
    ifa.mem_rvalid = 0; ifa.mem_ready = 0;
    total++; if (ifa.mem_valid !== 1'b1) begin bad++; $display("FAIL rm_pre got=%b exp=1", ifa.mem_valid); end
    rst_n = 0;
    #1;
    total++; if (ifa.req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", ifa.req_ready); end
    total++; if (ifa.mem_valid !== 1'b0 || ifa.mem_addr !== 32'h0 || ifa.mem_we !== 4'h0 || ifa.mem_wdata !== 32'h0) begin
      bad++; $display("FAIL rm_mem got=%b/%h/%h/%h exp=0/0/0/0", ifa.mem_valid, ifa.mem_addr, ifa.mem_we, ifa.mem_wdata);
    end
    total++; if (ifa.resp_valid !== 1'b0 || ifa.resp_data !== 32'h0 || ifa.resp_tgt !== 5'd0 || ifa.resp_split !== 1'b0 || ifa.resp_err !== 1'b0) begin
      bad++; $display("FAIL rm_resp got=%b/%h/%h/%b/%b exp=0/0/0/0/0", ifa.resp_valid, ifa.resp_data, ifa.resp_tgt, ifa.resp_split, ifa.resp_err);
    end
    step();
    rst_n = 1;
    step();
    total++; if (ifa.req_ready !== 1'b1 || ifa.mem_valid !== 1'b0) begin
      bad++; $display("FAIL rm_after got=%b/%b exp=1/0", ifa.req_ready, ifa.mem_valid);
    end
  endtask

  initial begin
    test_reset();
    test_store_aligned();
    test_store_split();
    test_load_split(1'b1, 32'hFFFFFFAB);
    test_load_split(1'b0, 32'h0000FFAB);
    test_load_stall();
    test_load_byte();
    test_error();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_split_access.md
# lsu_split_access

Parametrised load/store access unit between the execute stage and the data-memory port. Accepts one memory request at a time (byte, double, word, and quad when `DATA_BYTES`=8) and turns any access that crosses a bus-word boundary into two aligned beats. It handles misaligned loads (merge and sign/zero extend) as well as misaligned stores, with a valid/ready handshake to memory and a flush for exception/rfe kill.

## Interface
- `DATA_BYTES`, 4: memory bus width in bytes; legal values 4, 8. `OFF_W` = log2(`DATA_BYTES`).
- `ADDR_W`, 32: byte-address width.
- `ALLOW_MISALIGNED`, 1: 1 = split crossing accesses into two beats; 0 = crossing access returns an error response with no memory traffic.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset; asynchronous assert, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: equals (state == IDLE).
- `req_store` input 1: 1 = store, 0 = load.
- `req_size` input 2: access size, 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B.
- `req_signed` input 1: sign-extend the load result.
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input 8*DATA_BYTES: store data, right-justified.
- `req_tgt` input 5: destination register; returned unchanged.
- `flush` input 1: kill the in-flight request (exception or rfe in writeback).
- `mem_valid` output 1: beat request.
- `mem_ready` input 1: beat accepted.
- `mem_addr` output ADDR_W: beat address, aligned to DATA_BYTES.
- `mem_we` output DATA_BYTES: byte write enables; all 0 for loads.
- `mem_wdata` output 8*DATA_BYTES: lane-positioned store data.
- `mem_rvalid` input 1: read data for the oldest accepted load beat.
- `mem_rdata` input 8*DATA_BYTES: read data.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_data` output 8*DATA_BYTES: load result; 0 for stores and errors.
- `resp_tgt` output 5: destination register echoed from `req_tgt`.
- `resp_split` output 1: the access used two beats.
- `resp_err` output 1: access was illegal (size above bus width, or crossing with `ALLOW_MISALIGNED`=0).

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Also kept: beat counter `beat` (0/1), sticky `kill`, a 2*DATA_BYTES-byte merge buffer, and registered copies of all request fields.
- Accept: a request is taken when `req_valid` && `req_ready`. From that point the unit computes:
  - off = addr[OFF_W-1:0]
  - n = 1 << size
  - split = (off + n > DATA_BYTES)
  - base = addr with the low OFF_W bits cleared
- Error path: if size > OFF_W, or (split && !ALLOW_MISALIGNED), go straight to RESP with `resp_err`=1. No beat is issued.
- Otherwise go to ISSUE with `beat`=0.
- Beat 0:
  - address = base
  - lanes = off .. min(off+n, DATA_BYTES)-1
  - store data = wdata << 8*off
- Beat 1 (only when split):
  - address = base + DATA_BYTES; the add wraps modulo 2^ADDR_W
  - lanes = 0 .. off+n-DATA_BYTES-1
  - store data = wdata >> 8*(DATA_BYTES-off)
- ISSUE:
  - `mem_valid`=1. `mem_addr`, `mem_we` and `mem_wdata` stay stable until `mem_ready`.
  - On `mem_ready`, a load goes to WAIT.
  - On `mem_ready`, a store goes to ISSUE with `beat`=1 if split, and not killed, and `beat`=0. Otherwise it goes to RESP.
- WAIT:
  - On `mem_rvalid`, write rdata into merge-buffer half `beat`.
  - Then go to ISSUE with `beat`=1 if split, and not killed, and `beat`=0. Otherwise go to RESP.
  - `mem_rvalid` is ignored in every other state.
- Load result:
  - merged = buffer >> 8*off, truncated to n bytes.
  - Zero-extended, or sign-extended from bit 8n-1 when `req_signed`.
- RESP: lasts exactly one cycle, then IDLE.
  - `resp_valid`=1 unless `kill`.
  - `resp_tgt`, `resp_split` and `resp_err` are valid while `resp_valid`.
- Flush:
  - `flush` in any non-IDLE state sets `kill`. `flush` in IDLE has no effect. `flush` in the same cycle as accept kills the new request.
  - A beat already presented is never withdrawn.
  - A load still waits for the rvalid of an accepted beat.
  - No further beat is issued and no response is produced. Bytes already accepted by memory stay written.
  - `kill` clears on entering IDLE.
- Reset:
  - state IDLE; `kill`=0.
  - All outputs 0 except `req_ready`=1.
  - An in-flight request is abandoned; memory-side outstanding beats are the memory's concern.

## Timing
- Request accepted at cycle T, memory with `mem_ready`=1 and rvalid one cycle after acceptance:
  - Aligned store: beat at T+1, `resp_valid` at T+2.
  - Split store: beats at T+1 and T+2, resp at T+3.
  - Aligned load: beat T+1, rvalid T+2, resp T+3.
  - Split load: beat0 T+1, rvalid T+2, beat1 T+3, rvalid T+4, resp T+5.
  - Error: resp at T+1.
- Each `mem_ready` stall cycle adds one cycle. Each cycle of rvalid delay adds one cycle.
- `req_ready` is low from T+1 through the RESP cycle. A new request can be accepted in the cycle after RESP.

## Test plan
1. Store word 0xDEADBEEF at 0x100 (DATA_BYTES=4) -> one beat, addr 0x100, we 1111, wdata 0xDEADBEEF; resp at T+2, `resp_split`=0.
2. Store word 0x11223344 at 0x103 -> beat0 addr 0x100, we 1000, wdata 0x44000000; beat1 addr 0x104, we 0111, wdata 0x00112233; resp T+3, `resp_split`=1.
3. Load double at 0x203, rdata 0xAB000000 then 0x000000FF:
   - signed -> 0xFFFFFFAB
   - unsigned -> 0x0000FFAB
   - with `mem_ready` held low 3 cycles on beat1, addr/we stay stable and resp lands at T+8.
4. Load byte signed at 0x102, rdata 0x00800000 -> 0xFFFFFF80. Then load byte unsigned at 0x10 with the same rdata -> 0x00000000.
5. `ALLOW_MISALIGNED`=0:
   - load word at 0x101 -> no `mem_valid`, resp at T+1 with `resp_err`=1, data 0.
   - `req_size`=3 with DATA_BYTES=4 -> same error response.
6. Split store at 0x0FE with `flush` during beat0 while `mem_ready`=0 -> beat0 still completes; no beat1, no `resp_valid`; `req_ready`=1 next cycle. Then `rst_n` low mid-split-load -> IDLE immediately, all outputs 0 except `req_ready`=1.
